// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount sequencer and its accumulator.
package popcount_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

    localparam int unsigned SETTLE_DEF  = 12;
    localparam int unsigned RELEASE_DEF = 3;
    localparam int unsigned TOTAL_W_DEF = 16;
    localparam int unsigned COUNT_W     = 4;

    localparam logic [COUNT_W-1:0] TIMEOUT_COUNT = 4'hF;

    // The 3-bit counter wraps to 0 at eight ones; only a nonzero byte can mean 8.
    function automatic logic [COUNT_W-1:0] correct_count(input logic [2:0] raw,
                                                         input logic [7:0] data_v);
        if ((raw == 3'd0) && (data_v != 8'd0)) begin
            return 4'd8;
        end
        return {1'b0, raw};
    endfunction

endpackage

// File: rtl/popcount_total_acc.sv
// Saturating running-total accumulator; adds add_i when en_i and clamps at all-ones.
module popcount_total_acc #(
    parameter int unsigned TOTAL_W = 16,
    parameter int unsigned ADD_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [ADD_W-1:0]   add_i,
    output logic [TOTAL_W-1:0] total_o
);

    localparam int unsigned SUM_W = TOTAL_W + 1;

    logic [TOTAL_W-1:0] total_q, total_d;
    logic [SUM_W-1:0]   sum;

    always_comb begin
        sum     = {1'b0, total_q} + SUM_W'(add_i);
        total_d = total_q;
        if (en_i) begin
            total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total_o = total_q;

endmodule

// File: rtl/popcount_sequencer.sv
// Drives the serial bit-count unit one byte at a time and returns corrected counts.
// Optional stuck-counter timeout and err output enabled by POPSEQ_TIMEOUT_EN.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter int unsigned SETTLE  = SETTLE_DEF,
    parameter int unsigned RELEASE = RELEASE_DEF,
    parameter int unsigned TOTAL_W = TOTAL_W_DEF
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic [7:0]         cnt_a,
    output logic               cnt_load,
    output logic               cnt_start,
    input  logic               cnt_done,
    input  logic [2:0]         cnt_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_count,
    output logic [7:0]         out_data,
    output logic [TOTAL_W-1:0] total,
    output logic               busy
`ifdef POPSEQ_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned WCNT_MAX = (4 * SETTLE > RELEASE) ? 4 * SETTLE : RELEASE;
    localparam int unsigned WCNT_W   = $clog2(WCNT_MAX + 1);

    state_e               state_q, state_d;
    logic [WCNT_W-1:0]    wait_q, wait_d;
    logic [7:0]           data_q, data_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 acc_en;
`ifdef POPSEQ_TIMEOUT_EN
    logic                 err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        data_d    = data_q;
        count_d   = count_q;
`ifdef POPSEQ_TIMEOUT_EN
        err_d     = err_q;
`endif
        in_ready  = 1'b0;
        cnt_load  = 1'b0;
        cnt_start = 1'b0;
        out_valid = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    wait_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_load  = 1'b1;
                cnt_start = 1'b1;
                wait_d    = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_load  = 1'b1;
                cnt_start = 1'b1;
                // Saturate so an indefinite wait never wraps back under the settle gate.
                if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
                if ((wait_q >= WCNT_W'(SETTLE - 1)) && cnt_done) begin
                    count_d = correct_count(cnt_b, data_q);
                    wait_d  = '0;
                    state_d = ST_RELEASE;
                end
`ifdef POPSEQ_TIMEOUT_EN
                else if (wait_q >= WCNT_W'(4 * SETTLE - 1)) begin
                    count_d = TIMEOUT_COUNT;
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                wait_d = wait_q + 1'b1;
                if (wait_q >= WCNT_W'(RELEASE - 1)) begin
                    wait_d  = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef POPSEQ_TIMEOUT_EN
                    acc_en = !err_q;
                    err_d  = 1'b0;
`else
                    acc_en = 1'b1;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
`ifdef POPSEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef POPSEQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    popcount_total_acc #(
        .TOTAL_W (TOTAL_W),
        .ADD_W   (COUNT_W)
    ) u_total_acc (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .en_i    (acc_en),
        .add_i   (count_q),
        .total_o (total)
    );

    assign cnt_a     = data_q;
    assign out_data  = data_q;
    assign out_count = count_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef POPSEQ_TIMEOUT_EN
    assign err       = err_q;
`endif

endmodule

// File: doc/popcount_sequencer.md
Name: popcount_sequencer

Overview:
- Upstream driver and result collector for the 8-bit serial bit-count unit.
- Accepts bytes on a valid/ready stream and drives the counter's load/start/data inputs.
- Waits for the counter to complete, corrects the 3-bit result to a true 0..8 count, and presents it downstream with a valid/ready handshake.
- Keeps a saturating running total of all counts.

Parameters:
- SETTLE, 12, minimum cycles from cnt_start assertion to result capture; covers load + 8 shifts + finish.
- RELEASE, 3, cycles cnt_start is held low after capture so the counter returns to its load state.
- TOTAL_W, 16, width of the running-total register.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  block can accept a byte.
- in_data  in  8  byte to count.
- cnt_a  out  8  data to counter.
- cnt_load  out  1  counter load strobe.
- cnt_start  out  1  counter start level.
- cnt_done  in  1  counter done (level; may stay high between jobs).
- cnt_b  in  3  counter result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_count  out  4  corrected popcount, 0..8.
- out_data  out  8  byte the count belongs to.
- total  out  TOTAL_W  saturating sum of all accepted counts.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset is sampled on the ACLK rising edge and overrides everything:
  - state = IDLE.
  - All outputs = 0, except in_ready = 1.
  - total = 0; wait counter = 0.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_data into the byte register and go to ISSUE.
  - ISSUE, one cycle: cnt_a = byte register, cnt_load = 1, cnt_start = 1. Go to WAIT.
  - WAIT: cnt_start = 1, cnt_load = 1, cnt_a held, wait counter increments. When wait counter >= SETTLE-1 and cnt_done = 1, capture cnt_b and go to RELEASE.
  - RELEASE: cnt_start = 0, cnt_load = 0. After RELEASE cycles go to OUT.
  - OUT: out_valid = 1 with out_count/out_data stable. On out_ready go to IDLE; in_ready rises on the following cycle.
- Latency: byte accept to out_valid = 1 + SETTLE + RELEASE cycles minimum (16 with defaults).
- Only one job is in flight; in_ready = 0 in every state except IDLE. No skid buffer.
- Count correction: out_count = {1'b0, cnt_b}, except out_count = 8 when cnt_b = 0 and the byte is nonzero (the 3-bit counter wraps at 8 ones).
- total:
  - Updated on the out_valid & out_ready handshake: total += out_count.
  - Saturates at 2^TOTAL_W-1; never wraps.
- cnt_done is not edge-detected; it is qualified by the SETTLE gate only, so a stale done level from the previous job is ignored.
- out_ready held low: block stays in OUT indefinitely; outputs stay stable.
- Reset mid-job (any state): immediate return to IDLE with cnt_start/cnt_load = 0 and total cleared; the counter is reset by the same system reset.

Optional Feature:
- Macro: POPSEQ_TIMEOUT_EN.
- With it defined:
  - Adds output err (1 bit).
  - If cnt_done is still 0 when the wait counter reaches 4*SETTLE, capture out_count = 0xF and set err = 1 for the duration of OUT, then proceed to RELEASE/OUT as normal.
  - total is not updated for errored results.
  - err clears on the handshake.
- Without it: no err port; WAIT waits on cnt_done indefinitely.

Decomposition:
- Package popcount_pkg:
  - State encoding constants IDLE/ISSUE/WAIT/RELEASE/OUT (3-bit).
  - Default SETTLE/RELEASE values.
  - Count width constant (4).
  - Timeout sentinel 4'hF.
- Sub-module popcount_total_acc: saturating TOTAL_W accumulator with en/add inputs. Natural to isolate for reuse and separate unit test.
- The FSM and the wait counter stay in the top module.

Test Plan:
- Reset then byte 8'hA5 with counter model returning 4 → out_valid 16 cycles after accept, out_count = 4, out_data = A5, total = 4.
- Byte 8'hFF, model returns cnt_b = 0 → out_count = 8; byte 8'h00 with cnt_b = 0 → out_count = 0; total increases by 8 then 0.
- Stale cnt_done held high from the previous job, new byte 8'h01 → capture not before SETTLE cycles; out_count = 1.
- out_ready held low 20 cycles on a result → out_valid/out_count stable, in_ready = 0 throughout, total unchanged until handshake.
- Preload total near 0xFFFF via repeated 8'hFF jobs → total saturates at 0xFFFF and does not wrap.
- ARESET asserted during WAIT → next cycle state IDLE, cnt_start = 0, out_valid = 0, total = 0, in_ready = 1. With POPSEQ_TIMEOUT_EN, cnt_done stuck at 0 → err = 1, out_count = F at cycle 4*SETTLE.
